mem_stage_arbiter: RTL and testbench
====================================

# mem_stage_arbiter

Sequences every data-memory access of the 16-bit pipeline's memory stage and shares the single data-memory port with a DMA requester. Takes the MEM-stage control/address bundle, runs a wait-state-tolerant request/ready handshake to memory, and asserts a stall so upstream pipeline registers hold while an access is outstanding. Arbitration is CPU-first with a starvation limit for DMA.

## Interface
- AW, 16, address width
- DW, 16, data width
- STARVE_LIMIT, 4, consecutive contended CPU grants before DMA is forced through (1..15)
- TIMEOUT, 15, wait cycles before abort (only with MEM_TIMEOUT_EN; 1..255)
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- MemWriteM  in  1  MEM-stage store
- MemToRegM  in  1  MEM-stage load
- alu_resultM  in  AW  MEM-stage address
- wdataM  in  DW  MEM-stage store data
- stallM  out  1  freeze pipeline (combinational)
- cpu_rdata  out  DW  load data, registered
- cpu_rvalid  out  1  one-cycle pulse with cpu_rdata
- dma_req  in  1  DMA request, level, held until dma_gnt
- dma_we  in  1  DMA write
- dma_addr  in  AW  DMA address
- dma_wdata  in  DW  DMA write data
- dma_gnt  out  1  one-cycle pulse, request accepted
- dma_done  out  1  one-cycle pulse, access complete
- dma_rdata  out  DW  DMA read data, valid with dma_done
- mem_req  out  1  memory request, registered
- mem_we  out  1  write enable, registered
- mem_addr  out  AW  registered
- mem_wdata  out  DW  registered
- mem_rdata  in  DW  valid when mem_ready high
- mem_ready  in  1  access completes on this edge
- bus_err  out  1  sticky timeout flag

## Operation
- cpu_req = MemWriteM | MemToRegM; both high treated as write.
- FSM states IDLE, CPU_ACC, DMA_ACC. mem_req = 1 exactly when state != IDLE.
- IDLE: cpu_req & dma_req: DMA wins iff starve_cnt == STARVE_LIMIT, else CPU. Only one: that one. Winner's address/data/we latched into mem_* regs; state -> CPU_ACC or DMA_ACC. DMA win pulses dma_gnt same edge.
- starve_cnt: +1 (saturating at STARVE_LIMIT) on each CPU grant while dma_req high; cleared on DMA grant or any cycle dma_req low.
- CPU_ACC/DMA_ACC: mem_* held stable. On edge with mem_ready=1: capture mem_rdata into cpu_rdata/dma_rdata, pulse cpu_rvalid/dma_done next cycle, state -> IDLE. Writes also pulse valid/done; rdata register loaded with mem_rdata regardless.
- stallM = cpu_req & ~(state==CPU_ACC & mem_ready); forced 0 while reset high.
- No back-to-back grants: IDLE is always visited between accesses.

## Timing
- Reset values: state IDLE, mem_req/mem_we 0, mem_addr/mem_wdata/cpu_rdata/dma_rdata 0, cpu_rvalid/dma_gnt/dma_done 0, starve_cnt 0, bus_err 0.
- CPU access with zero wait states: 2 cycles (IDLE grant + CPU_ACC); stallM high 1 cycle. Each wait state adds 1 stall cycle.
- CPU request arriving while DMA_ACC in progress: stallM high through DMA completion, IDLE grant, and own access.
- dma_done asserted the cycle after mem_ready edge; dma_gnt the cycle after IDLE decision.
- dma_req dropped before dma_gnt: request withdrawn, no access.
- Reset mid-access: next edge returns IDLE, mem_req 0, in-flight data discarded, no done/valid pulse.

## Configuration
- MEM_TIMEOUT_EN defined: wait counter clears on entering an ACC state, increments each ACC cycle with mem_ready=0; when it reaches TIMEOUT, access aborted: state -> IDLE, mem_req drops, bus_err set (sticky until reset), completion pulse issued with rdata 0 so stallM releases on the abort cycle.
- Undefined: no counter; ACC waits indefinitely; bus_err constant 0.

## Test plan
- Load, mem_ready tied 1, addr 0x0040, mem_rdata 0xBEEF -> stallM high 1 cycle, cpu_rdata=0xBEEF with cpu_rvalid, mem_we=0.
- Store addr 0x0100 data 0x1234, mem_ready after 3 wait cycles -> mem_* stable 4 cycles, stallM high 4 cycles, mem_we=1.
- dma_req held with continuous CPU loads, STARVE_LIMIT=4 -> exactly 4 CPU grants, then dma_gnt, DMA access, starve_cnt 0.
- DMA read addr 0x0200 in DMA_ACC while CPU load arrives -> dma_done with 0x5A5A, then CPU granted, stallM held until CPU completion.
- Reset asserted during CPU_ACC with mem_ready=0 -> next cycle mem_req=0, state IDLE, no cpu_rvalid.
- MEM_TIMEOUT_EN, TIMEOUT=15, mem_ready stuck 0 -> abort after 15 ACC cycles, bus_err=1, cpu_rdata=0, stallM released; without macro bus_err stays 0 and stall persists.

Source files
------------

// File: rtl/mem_stage_arbiter_if.sv
// Data-memory port bus: the MEM-stage arbiter drives it as master, the memory answers as slave.
interface mem_stage_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_stage_arbiter.sv
// MEM-stage data-memory sequencer sharing one memory port between the CPU and a DMA requester.
// Optional access timeout with sticky bus_err is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemWriteM,
    input  logic                MemToRegM,
    input  logic [AW-1:0]       alu_resultM,
    input  logic [DW-1:0]       wdataM,
    output logic                stallM,
    output logic [DW-1:0]       cpu_rdata,
    output logic                cpu_rvalid,
    input  logic                dma_req,
    input  logic                dma_we,
    input  logic [AW-1:0]       dma_addr,
    input  logic [DW-1:0]       dma_wdata,
    output logic                dma_gnt,
    output logic                dma_done,
    output logic [DW-1:0]       dma_rdata,
    mem_stage_arbiter_if.master memBus,
    output logic                bus_err
);

    typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} state_t;

    state_t        r_state;
    state_t        w_nextState;

    logic          w_cpuReq;
    logic          w_grantCpu;
    logic          w_grantDma;
    logic          w_finish;
    logic          w_abort;
    logic [DW-1:0] w_rdataIn;

    logic [3:0]    r_starveCnt;
    logic          r_memReq;
    logic          r_memWe;
    logic [AW-1:0] r_memAddr;
    logic [DW-1:0] r_memWdata;
    logic [DW-1:0] r_cpuRdata;
    logic          r_cpuRvalid;
    logic [DW-1:0] r_dmaRdata;
    logic          r_dmaDone;
    logic          r_dmaGnt;

    assign w_cpuReq = MemWriteM | MemToRegM;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // CPU wins contention unless DMA has been passed over STARVE_LIMIT times in a row
    always_comb begin
        w_nextState = r_state;
        w_grantCpu  = 1'b0;
        w_grantDma  = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (dma_req && (!w_cpuReq || r_starveCnt == 4'(STARVE_LIMIT))) begin
                    w_grantDma  = 1'b1;
                    w_nextState = DMA_ACC;
                end else if (w_cpuReq) begin
                    w_grantCpu  = 1'b1;
                    w_nextState = CPU_ACC;
                end
            end
            CPU_ACC, DMA_ACC: begin
                if (memBus.mem_ready || w_abort) begin
                    w_finish    = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign w_rdataIn = w_abort ? '0 : memBus.mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starveCnt <= '0;
            r_memReq    <= 1'b0;
            r_memWe     <= 1'b0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
            r_cpuRdata  <= '0;
            r_cpuRvalid <= 1'b0;
            r_dmaRdata  <= '0;
            r_dmaDone   <= 1'b0;
            r_dmaGnt    <= 1'b0;
        end else begin
            r_cpuRvalid <= 1'b0;
            r_dmaDone   <= 1'b0;
            r_dmaGnt    <= w_grantDma;
            r_memReq    <= (w_nextState != IDLE);

            if (w_grantCpu) begin
                r_memWe    <= MemWriteM;
                r_memAddr  <= alu_resultM;
                r_memWdata <= wdataM;
            end else if (w_grantDma) begin
                r_memWe    <= dma_we;
                r_memAddr  <= dma_addr;
                r_memWdata <= dma_wdata;
            end

            if (w_finish && r_state == CPU_ACC) begin
                r_cpuRdata  <= w_rdataIn;
                r_cpuRvalid <= 1'b1;
            end else if (w_finish && r_state == DMA_ACC) begin
                r_dmaRdata  <= w_rdataIn;
                r_dmaDone   <= 1'b1;
            end

            // Counts only grants the CPU takes while DMA is actually waiting
            if (!dma_req || w_grantDma) begin
                r_starveCnt <= '0;
            end else if (w_grantCpu && r_starveCnt != 4'(STARVE_LIMIT)) begin
                r_starveCnt <= r_starveCnt + 4'd1;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] r_waitCnt;
    logic       r_busErr;

    // Abort lands on the TIMEOUT-th waiting ACC cycle so the stall releases in that same cycle
    assign w_abort = (r_state != IDLE) && !memBus.mem_ready && (r_waitCnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_waitCnt <= '0;
            r_busErr  <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_waitCnt <= '0;
            end else if (!memBus.mem_ready) begin
                r_waitCnt <= r_waitCnt + 8'd1;
            end
            if (w_abort) begin
                r_busErr <= 1'b1;
            end
        end
    end

    assign bus_err = r_busErr;
`else
    assign w_abort = 1'b0;
    assign bus_err = 1'b0;
`endif

    assign stallM = !reset && w_cpuReq && !(r_state == CPU_ACC && w_finish);

    assign cpu_rdata        = r_cpuRdata;
    assign cpu_rvalid       = r_cpuRvalid;
    assign dma_rdata        = r_dmaRdata;
    assign dma_done         = r_dmaDone;
    assign dma_gnt          = r_dmaGnt;
    assign memBus.mem_req   = r_memReq;
    assign memBus.mem_we    = r_memWe;
    assign memBus.mem_addr  = r_memAddr;
    assign memBus.mem_wdata = r_memWdata;

endmodule

// File: tb/tb_mem_stage_arbiter.sv
// Directed bench for mem_stage_arbiter: completion data is scoreboarded, stall/bus signals checked per cycle.
module tb_mem_stage_arbiter;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic        MemToRegM;
    logic [15:0] alu_resultM;
    logic [15:0] wdataM;
    logic        stallM;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_done;
    logic [15:0] dma_rdata;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] cpuQ[$];
    logic [15:0] dmaQ[$];

    mem_stage_arbiter_if #(.AW(16), .DW(16)) memBus ();

    mem_stage_arbiter #(
        .AW(16), .DW(16), .STARVE_LIMIT(4), .TIMEOUT(15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MemWriteM   (MemWriteM),
        .MemToRegM   (MemToRegM),
        .alu_resultM (alu_resultM),
        .wdataM      (wdataM),
        .stallM      (stallM),
        .cpu_rdata   (cpu_rdata),
        .cpu_rvalid  (cpu_rvalid),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_gnt     (dma_gnt),
        .dma_done    (dma_done),
        .dma_rdata   (dma_rdata),
        .memBus      (memBus),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete CPU access starting in IDLE; memory answers after 'waits' wait states
    task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] rdata, input int waits);
        MemWriteM        = we;
        MemToRegM        = ~we;
        alu_resultM      = addr;
        wdataM           = wdata;
        memBus.mem_ready = 1'b0;
        cpuQ.push_back(rdata);
        #1 checkOutput("stall_grant_cycle", stallM, 1);
        tick();
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) begin
                memBus.mem_ready = 1'b1;
                memBus.mem_rdata = rdata;
            end
            #1;
            checkOutput("stall_acc", stallM, (i == waits) ? 0 : 1);
            checkOutput("mem_req_acc", memBus.mem_req, 1);
            checkOutput("mem_addr_stable", memBus.mem_addr, addr);
            checkOutput("mem_we_stable", memBus.mem_we, we);
            if (we) checkOutput("mem_wdata_stable", memBus.mem_wdata, wdata);
            tick();
        end
        MemWriteM        = 1'b0;
        MemToRegM        = 1'b0;
        memBus.mem_ready = 1'b0;
    endtask

    // Completion monitor pops the scoreboard whenever a valid/done pulse appears
    always @(negedge clk) begin
        if (cpu_rvalid === 1'b1) begin
            if (cpuQ.size() == 0) checkOutput("cpu_rvalid_unexpected", cpu_rvalid, 0);
            else checkOutput("cpu_rdata", cpu_rdata, cpuQ.pop_front());
        end
        if (dma_done === 1'b1) begin
            if (dmaQ.size() == 0) checkOutput("dma_done_unexpected", dma_done, 0);
            else checkOutput("dma_rdata", dma_rdata, dmaQ.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset            = 1'b1;
        MemWriteM        = 1'b0;
        MemToRegM        = 1'b1;
        alu_resultM      = 16'h0;
        wdataM           = 16'h0;
        dma_req          = 1'b0;
        dma_we           = 1'b0;
        dma_addr         = 16'h0;
        dma_wdata        = 16'h0;
        memBus.mem_ready = 1'b0;
        memBus.mem_rdata = 16'h0;
        tick();
        tick();
        checkOutput("stall_forced_in_reset", stallM, 0);
        MemToRegM = 1'b0;
        reset     = 1'b0;
        tick();
        checkOutput("reset_mem_req", memBus.mem_req, 0);
        checkOutput("reset_mem_we", memBus.mem_we, 0);
        checkOutput("reset_mem_addr", memBus.mem_addr, 0);
        checkOutput("reset_cpu_rdata", cpu_rdata, 0);
        checkOutput("reset_cpu_rvalid", cpu_rvalid, 0);
        checkOutput("reset_dma_gnt", dma_gnt, 0);
        checkOutput("reset_bus_err", bus_err, 0);

        $display("[TB] zero-wait load and 3-wait store");
        applyStimulus(1'b0, 16'h0040, 16'h0000, 16'hBEEF, 0);
        checkOutput("mem_req_after_load", memBus.mem_req, 0);
        applyStimulus(1'b1, 16'h0100, 16'h1234, 16'h7777, 3);

        $display("[TB] DMA starvation limit");
        dma_req  = 1'b1;
        dma_we   = 1'b0;
        dma_addr = 16'h0300;
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1'b0, 16'h0080 + 16'(n), 16'h0000, 16'h1000 + 16'(n), 0);
        end
        MemToRegM   = 1'b1;
        alu_resultM = 16'h0044;
        #1 checkOutput("stall_while_dma_forced", stallM, 1);
        tick();
        checkOutput("dma_gnt_after_starve", dma_gnt, 1);
        checkOutput("dma_mem_addr", memBus.mem_addr, 16'h0300);
        checkOutput("dma_mem_we", memBus.mem_we, 0);
        checkOutput("starve_cnt_cleared", dut.r_starveCnt, 0);
        dma_req          = 1'b0;
        memBus.mem_ready = 1'b1;
        memBus.mem_rdata = 16'hCAFE;
        dmaQ.push_back(16'hCAFE);
        #1 checkOutput("stall_during_dma", stallM, 1);
        tick();
        checkOutput("dma_gnt_one_cycle", dma_gnt, 0);
        applyStimulus(1'b0, 16'h0044, 16'h0000, 16'h4444, 0);

        $display("[TB] CPU load arriving during DMA access");
        dma_req  = 1'b1;
        dma_addr = 16'h0200;
        #1 checkOutput("no_stall_without_cpu", stallM, 0);
        tick();
        checkOutput("dma_gnt_uncontended", dma_gnt, 1);
        dma_req     = 1'b0;
        MemToRegM   = 1'b1;
        alu_resultM = 16'h0050;
        #1 checkOutput("stall_cpu_behind_dma_wait", stallM, 1);
        tick();
        memBus.mem_ready = 1'b1;
        memBus.mem_rdata = 16'h5A5A;
        dmaQ.push_back(16'h5A5A);
        #1 checkOutput("stall_cpu_behind_dma_done", stallM, 1);
        tick();
        applyStimulus(1'b0, 16'h0050, 16'h0000, 16'h1111, 1);

        $display("[TB] reset during CPU access");
        MemToRegM   = 1'b1;
        alu_resultM = 16'h0060;
        tick();
        checkOutput("mem_req_before_reset", memBus.mem_req, 1);
        reset = 1'b1;
        #1 checkOutput("stall_forced_mid_access", stallM, 0);
        tick();
        checkOutput("mem_req_after_reset", memBus.mem_req, 0);
        checkOutput("rvalid_after_reset", cpu_rvalid, 0);
        reset     = 1'b0;
        MemToRegM = 1'b0;
        tick();
        checkOutput("mem_req_idle_post_reset", memBus.mem_req, 0);
        checkOutput("rvalid_idle_post_reset", cpu_rvalid, 0);

        $display("[TB] memory never ready");
        MemToRegM   = 1'b1;
        alu_resultM = 16'h0070;
        tick();
`ifdef MEM_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            if (k == 15) cpuQ.push_back(16'h0000);
            #1 checkOutput("stall_until_abort", stallM, (k == 15) ? 0 : 1);
            tick();
        end
        MemToRegM = 1'b0;
        checkOutput("bus_err_after_abort", bus_err, 1);
        checkOutput("mem_req_after_abort", memBus.mem_req, 0);
        tick();
        checkOutput("bus_err_sticky", bus_err, 1);
`else
        for (int k = 1; k <= 20; k++) begin
            #1 checkOutput("stall_persists", stallM, 1);
            checkOutput("bus_err_stays_low", bus_err, 0);
            tick();
        end
        memBus.mem_ready = 1'b1;
        memBus.mem_rdata = 16'h2222;
        cpuQ.push_back(16'h2222);
        #1 checkOutput("stall_release_late_ready", stallM, 0);
        tick();
        MemToRegM        = 1'b0;
        memBus.mem_ready = 1'b0;
`endif
        tick();
        tick();
        checkOutput("cpu_scoreboard_drained", cpuQ.size(), 0);
        checkOutput("dma_scoreboard_drained", dmaQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
